// File: rtl/data_mem_responder_pkg.sv
// data_mem_pkg: shared widths and FSM state type for data_mem_responder.
package data_mem_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned MASK_W = 4;
  localparam int unsigned CNT_W  = 4;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    WAIT = 2'd1,
    RESP = 2'd2
  } state_t;

endpackage

// File: rtl/data_mem_responder_byte_lane_ram.sv
// byte_lane_ram: DEPTH_WORDS x 32 array, per-byte write enables, registered read.
// Ports: clk, rst (async, clears the read register only), en (access strobe),
// we (1 = write), be (byte enables), addr (word index), wdata, rdata
// (read word on read accesses, zero on write accesses).
module byte_lane_ram
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned ADDR_W      = $clog2(DEPTH_WORDS)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              en,
  input  logic              we,
  input  logic [MASK_W-1:0] be,
  input  logic [ADDR_W-1:0] addr,
  input  logic [WORD_W-1:0] wdata,
  output logic [WORD_W-1:0] rdata
);

  logic [WORD_W-1:0] mem [DEPTH_WORDS];

  always_ff @(posedge clk) begin
    if (en && we) begin
      for (int unsigned b = 0; b < MASK_W; b++) begin
        if (be[b]) mem[addr][8*b +: 8] <= wdata[8*b +: 8];
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst)     rdata <= '0;
    else if (en) rdata <= we ? '0 : mem[addr];
  end

endmodule

// File: rtl/data_mem_responder.sv
// data_mem_responder: single-outstanding data-memory responder with LATENCY
// wait states, byte-masked writes and full-word registered reads.
// Ports: clk, rst (async active-high), request, we_re, mask, address,
// store_data in; valid (one-cycle completion), load_data, err, busy out.
// Optional macro DATA_MEM_RANGE_CHECK_EN: out-of-range byte addresses complete
// with err=1, load_data=0 and no write; otherwise addresses wrap.
module data_mem_responder
  import data_mem_pkg::*;
#(
  parameter int unsigned DEPTH_WORDS = 1024,
  parameter int unsigned LATENCY     = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              request,
  input  logic              we_re,
  input  logic [MASK_W-1:0] mask,
  input  logic [31:0]       address,
  input  logic [WORD_W-1:0] store_data,
  output logic              valid,
  output logic [WORD_W-1:0] load_data,
  output logic              err,
  output logic              busy
);

  localparam int unsigned AW     = $clog2(DEPTH_WORDS);
  localparam bit          DIRECT = (LATENCY == 1);

  state_t            state, state_nxt;
  logic [CNT_W-1:0]  cnt;
  logic              cap_we;
  logic [MASK_W-1:0] cap_mask;
  logic [AW-1:0]     cap_idx;
  logic [WORD_W-1:0] cap_data;
  logic              cap_oor;

  logic              req_oor;
  logic              accept;
  logic              fire;
  logic              sel_we;
  logic [MASK_W-1:0] sel_mask;
  logic [AW-1:0]     sel_idx;
  logic [WORD_W-1:0] sel_data;
  logic              sel_oor;
  logic              unused_lo;

  assign unused_lo = ^address[1:0];

`ifdef DATA_MEM_RANGE_CHECK_EN
  assign req_oor = |address[31:AW+2];
`else
  logic unused_hi;
  assign req_oor   = 1'b0;
  assign unused_hi = ^address[31:AW+2];
`endif

  assign accept = request && ((state == IDLE) || (state == RESP));

  // With LATENCY=1 the access completes on the accept edge itself, so the
  // memory sees the live request; otherwise it sees the captured one.
  always_comb begin
    if (DIRECT) begin
      fire     = accept;
      sel_we   = we_re;
      sel_mask = mask;
      sel_idx  = address[AW+1:2];
      sel_data = store_data;
      sel_oor  = req_oor;
    end else begin
      fire     = (state == WAIT) && (cnt == CNT_W'(1));
      sel_we   = cap_we;
      sel_mask = cap_mask;
      sel_idx  = cap_idx;
      sel_data = cap_data;
      sel_oor  = cap_oor;
    end
    fire = fire && !rst;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE: if (request) state_nxt = DIRECT ? RESP : WAIT;
      WAIT: if (cnt == CNT_W'(1)) state_nxt = RESP;
      RESP: state_nxt = request ? (DIRECT ? RESP : WAIT) : IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      cnt      <= '0;
      cap_we   <= 1'b0;
      cap_mask <= '0;
      cap_idx  <= '0;
      cap_data <= '0;
      cap_oor  <= 1'b0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        cap_we   <= we_re;
        cap_mask <= mask;
        cap_idx  <= address[AW+1:2];
        cap_data <= store_data;
        cap_oor  <= req_oor;
        cnt      <= CNT_W'(LATENCY - 1);
      end else if (state == WAIT) begin
        cnt <= cnt - CNT_W'(1);
      end
    end
  end

  assign valid = (state == RESP);
  assign busy  = (state == WAIT);

`ifdef DATA_MEM_RANGE_CHECK_EN
  always_ff @(posedge clk or posedge rst) begin
    if (rst) err <= 1'b0;
    else     err <= fire && sel_oor;
  end
`else
  assign err = 1'b0;
`endif

  // A faulting access is turned into a write with no byte enables: nothing
  // changes in the array and the read register returns zero.
  byte_lane_ram #(
    .DEPTH_WORDS (DEPTH_WORDS),
    .ADDR_W      (AW)
  ) u_ram (
    .clk   (clk),
    .rst   (rst),
    .en    (fire),
    .we    (sel_we || sel_oor),
    .be    (sel_oor ? '0 : sel_mask),
    .addr  (sel_idx),
    .wdata (sel_data),
    .rdata (load_data)
  );

endmodule

// File: tb/tb_data_mem_responder.sv
module tb_data_mem_responder;

  logic        clk;
  logic        rst;
  logic        req   [3];
  logic        we    [3];
  logic [3:0]  msk   [3];
  logic [31:0] adr   [3];
  logic [31:0] sd    [3];
  logic        vld   [3];
  logic [31:0] ld    [3];
  logic        er    [3];
  logic        bsy   [3];

  int          lat_of [3] = '{1, 2, 3};
  logic [31:0] mm [3][1024];
  int passed = 0;
  int total  = 0;

  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .request(req[0]), .we_re(we[0]), .mask(msk[0]),
    .address(adr[0]), .store_data(sd[0]), .valid(vld[0]), .load_data(ld[0]),
    .err(er[0]), .busy(bsy[0]));
  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst), .request(req[1]), .we_re(we[1]), .mask(msk[1]),
    .address(adr[1]), .store_data(sd[1]), .valid(vld[1]), .load_data(ld[1]),
    .err(er[1]), .busy(bsy[1]));
  data_mem_responder #(.DEPTH_WORDS(1024), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .request(req[2]), .we_re(we[2]), .mask(msk[2]),
    .address(adr[2]), .store_data(sd[2]), .valid(vld[2]), .load_data(ld[2]),
    .err(er[2]), .busy(bsy[2]));

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: word-addressed array, byte merge, out-of-range rule.
  function automatic void model(input int d, input bit w, input logic [3:0] m,
                                input logic [31:0] a, input logic [31:0] data,
                                output logic [31:0] erd, output logic ee);
    int unsigned idx;
`ifdef DATA_MEM_RANGE_CHECK_EN
    if (a >= 32'd4096) begin
      erd = '0; ee = 1'b1;
      return;
    end
`endif
    idx = (a / 4) % 1024;
    ee  = 1'b0;
    if (w) begin
      for (int b = 0; b < 4; b++)
        if (m[b]) mm[d][idx][8*b +: 8] = data[8*b +: 8];
      erd = '0;
    end else begin
      erd = mm[d][idx];
    end
  endfunction

  // Called at a negedge with the DUT idle or in RESP; returns at the negedge
  // of the completion cycle.
  task automatic issue(input int d, input bit w, input logic [3:0] m,
                       input logic [31:0] a, input logic [31:0] data,
                       output int lat, output int bcnt,
                       output logic [31:0] rd, output logic e);
    req[d] = 1'b1; we[d] = w; msk[d] = m; adr[d] = a; sd[d] = data;
    lat = -1; bcnt = 0; rd = 'x; e = 1'bx;
    for (int n = 1; n <= 20; n++) begin
      @(negedge clk);
      if (n == 1) req[d] = 1'b0;
      if (bsy[d]) bcnt++;
      if (vld[d]) begin
        lat = n; rd = ld[d]; e = er[d];
        break;
      end
    end
  endtask

  task automatic test_reset;
    rst = 1'b1;
    for (int d = 0; d < 3; d++) begin
      req[d] = 0; we[d] = 0; msk[d] = 0; adr[d] = 0; sd[d] = 0;
    end
    repeat (2) @(negedge clk);
    for (int d = 0; d < 3; d++) begin
      total++;
      if (vld[d] !== 1'b0 || bsy[d] !== 1'b0 || er[d] !== 1'b0 || ld[d] !== 32'h0)
        $display("FAIL reset_outputs dut%0d: valid=%b busy=%b err=%b load=%h required 0 0 0 0",
                 d, vld[d], bsy[d], er[d], ld[d]);
      else passed++;
    end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_write_read;
    int lat, bc; logic [31:0] rd, erd; logic e, ee;
    model(1, 1, 4'hF, 32'h10, 32'hDEADBEEF, erd, ee);
    issue(1, 1, 4'hF, 32'h10, 32'hDEADBEEF, lat, bc, rd, e);
    total++;
    if (lat !== 2 || rd !== 32'h0) $display("FAIL write_full: lat=%0d load=%h required 2 00000000", lat, rd);
    else passed++;
    @(negedge clk);
    total++;
    if (vld[1] !== 1'b0) $display("FAIL valid_pulse_width: valid=%b required 0", vld[1]);
    else passed++;
    model(1, 0, 4'h0, 32'h10, 32'h0, erd, ee);
    issue(1, 0, 4'h0, 32'h10, 32'h0, lat, bc, rd, e);
    total++;
    if (lat !== 2 || rd !== 32'hDEADBEEF || erd !== 32'hDEADBEEF || bc !== 1)
      $display("FAIL read_full: lat=%0d load=%h busy_cycles=%0d required 2 deadbeef 1", lat, rd, bc);
    else passed++;
  endtask

  task automatic test_partial_write;
    int lat, bc; logic [31:0] rd, erd; logic e, ee;
    model(1, 1, 4'b0010, 32'h10, 32'h0000AB00, erd, ee);
    issue(1, 1, 4'b0010, 32'h10, 32'h0000AB00, lat, bc, rd, e);
    model(1, 0, 4'hF, 32'h10, 32'h0, erd, ee);
    issue(1, 0, 4'hF, 32'h10, 32'h0, lat, bc, rd, e);
    total++;
    if (rd !== 32'hDEADABEF || erd !== 32'hDEADABEF)
      $display("FAIL partial_write: load=%h required deadabef", rd);
    else passed++;
  endtask

  task automatic test_back_to_back;
    int lat, bc; logic [31:0] rd, erd; logic e, ee;
    logic [31:0] exp [4];
    for (int i = 0; i < 4; i++) begin
      model(0, 1, 4'hF, 32'(i * 4), 32'hC0DE0000 + 32'(i), erd, ee);
      issue(0, 1, 4'hF, 32'(i * 4), 32'hC0DE0000 + 32'(i), lat, bc, rd, e);
    end
    @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      req[0] = 1'b1; we[0] = 1'b0; msk[0] = 4'h0; adr[0] = 32'(i * 4);
      model(0, 0, 4'h0, 32'(i * 4), 32'h0, exp[i], ee);
      @(negedge clk);
      total++;
      if (vld[0] !== 1'b1 || bsy[0] !== 1'b0 || ld[0] !== exp[i])
        $display("FAIL back_to_back[%0d]: valid=%b busy=%b load=%h required 1 0 %h",
                 i, vld[0], bsy[0], ld[0], exp[i]);
      else passed++;
    end
    req[0] = 1'b0;
    @(negedge clk);
    total++;
    if (vld[0] !== 1'b0) $display("FAIL back_to_back_end: valid=%b required 0", vld[0]);
    else passed++;
  endtask

  task automatic test_wait_ignore;
    int lat, bc, nv, nb; logic [31:0] rd, erd, exp, got; logic e, ee;
    model(2, 1, 4'hF, 32'h40, 32'h0BADF00D, erd, ee);
    issue(2, 1, 4'hF, 32'h40, 32'h0BADF00D, lat, bc, rd, e);
    model(2, 1, 4'hF, 32'h44, 32'h11112222, erd, ee);
    issue(2, 1, 4'hF, 32'h44, 32'h11112222, lat, bc, rd, e);
    @(negedge clk);
    model(2, 0, 4'h0, 32'h44, 32'h0, exp, ee);
    req[2] = 1'b1; we[2] = 1'b0; adr[2] = 32'h44;
    nv = 0; nb = 0; got = 'x;
    for (int n = 1; n <= 8; n++) begin
      @(negedge clk);
      // Stray writes while the read is waiting must be dropped.
      req[2] = (n <= 2); we[2] = 1'b1; msk[2] = 4'hF; adr[2] = 32'h40; sd[2] = 32'hFFFFFFFF;
      if (vld[2]) begin nv++; got = ld[2]; end
      if (bsy[2]) nb++;
    end
    total++;
    if (nv !== 1 || nb !== 2 || got !== exp)
      $display("FAIL wait_ignore: valids=%0d busy=%0d load=%h required 1 2 %h", nv, nb, got, exp);
    else passed++;
    model(2, 0, 4'h0, 32'h40, 32'h0, erd, ee);
    issue(2, 0, 4'h0, 32'h40, 32'h0, lat, bc, rd, e);
    total++;
    if (rd !== erd || lat !== 3) $display("FAIL wait_ignore_nowrite: load=%h lat=%0d required %h 3", rd, lat, erd);
    else passed++;
  endtask

  task automatic test_reset_in_flight;
    int lat, bc; logic [31:0] rd, erd; logic e, ee;
    model(2, 1, 4'hF, 32'h20, 32'h12345678, erd, ee);
    issue(2, 1, 4'hF, 32'h20, 32'h12345678, lat, bc, rd, e);
    @(negedge clk);
    req[2] = 1'b1; we[2] = 1'b1; msk[2] = 4'hF; adr[2] = 32'h20; sd[2] = 32'hFFFFFFFF;
    @(negedge clk);
    req[2] = 1'b0;
    total++;
    if (bsy[2] !== 1'b1) $display("FAIL reset_wait_pre: busy=%b required 1", bsy[2]);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if (vld[2] !== 1'b0 || bsy[2] !== 1'b0) $display("FAIL reset_wait_drop: valid=%b busy=%b required 0 0", vld[2], bsy[2]);
    else passed++;
    repeat (3) @(negedge clk);
    rst = 1'b0;
    model(2, 0, 4'h0, 32'h20, 32'h0, erd, ee);
    issue(2, 0, 4'h0, 32'h20, 32'h0, lat, bc, rd, e);
    total++;
    if (rd !== 32'h12345678 || erd !== 32'h12345678 || lat !== 3)
      $display("FAIL reset_wait_discard: load=%h lat=%0d required 12345678 3", rd, lat);
    else passed++;
    // Reset during RESP must drop valid asynchronously.
    issue(1, 0, 4'h0, 32'h10, 32'h0, lat, bc, rd, e);
    total++;
    if (vld[1] !== 1'b1) $display("FAIL reset_resp_pre: valid=%b required 1", vld[1]);
    else passed++;
    #2 rst = 1'b1;
    #1;
    total++;
    if (vld[1] !== 1'b0 || ld[1] !== 32'h0) $display("FAIL reset_resp_drop: valid=%b load=%h required 0 00000000", vld[1], ld[1]);
    else passed++;
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_range;
    int lat, bc; logic [31:0] rd, erd; logic e, ee;
    model(1, 1, 4'hF, 32'h0, 32'hA5A50001, erd, ee);
    issue(1, 1, 4'hF, 32'h0, 32'hA5A50001, lat, bc, rd, e);
    model(1, 1, 4'hF, 32'h4, 32'hA5A50002, erd, ee);
    issue(1, 1, 4'hF, 32'h4, 32'hA5A50002, lat, bc, rd, e);
    model(1, 0, 4'h0, 32'h1000, 32'h0, erd, ee);
    issue(1, 0, 4'h0, 32'h1000, 32'h0, lat, bc, rd, e);
    total++;
    if (lat !== 2 || rd !== erd || e !== ee)
      $display("FAIL range_read: lat=%0d load=%h err=%b required 2 %h %b", lat, rd, e, erd, ee);
    else passed++;
    model(1, 1, 4'hF, 32'h1006, 32'h77777777, erd, ee);
    issue(1, 1, 4'hF, 32'h1006, 32'h77777777, lat, bc, rd, e);
    total++;
    if (lat !== 2 || rd !== 32'h0 || e !== ee)
      $display("FAIL range_write: lat=%0d load=%h err=%b required 2 00000000 %b", lat, rd, e, ee);
    else passed++;
    model(1, 0, 4'h0, 32'h4, 32'h0, erd, ee);
    issue(1, 0, 4'h0, 32'h4, 32'h0, lat, bc, rd, e);
    total++;
    if (rd !== erd || e !== 1'b0) $display("FAIL range_after: load=%h err=%b required %h 0", rd, e, erd);
    else passed++;
  endtask

  task automatic test_random;
    int lat, bc; logic [31:0] rd, erd, a, data; logic e, ee; bit w; logic [3:0] m;
    for (int d = 0; d < 3; d++) begin
      for (int i = 0; i < 16; i++) begin
        data = $urandom;
        model(d, 1, 4'hF, 32'(i * 4), data, erd, ee);
        issue(d, 1, 4'hF, 32'(i * 4), data, lat, bc, rd, e);
      end
      for (int k = 0; k < 40; k++) begin
        repeat ($urandom_range(0, 2)) @(negedge clk);
        w    = 1'($urandom_range(0, 1));
        m    = 4'($urandom);
        a    = 32'($urandom_range(0, 15) * 4 + $urandom_range(0, 3));
        if ($urandom_range(0, 3) == 0) a = a + 32'h1000;
        data = $urandom;
        model(d, w, m, a, data, erd, ee);
        issue(d, w, m, a, data, lat, bc, rd, e);
        total++;
        if (lat !== lat_of[d] || rd !== erd || e !== ee || bc !== lat_of[d] - 1)
          $display("FAIL random dut%0d op%0d we=%b a=%h: lat=%0d busy=%0d load=%h err=%b required %0d %0d %h %b",
                   d, k, w, a, lat, bc, rd, e, lat_of[d], lat_of[d] - 1, erd, ee);
        else passed++;
      end
      @(negedge clk);
    end
  endtask

  initial begin
    test_reset;
    test_write_read;
    test_partial_write;
    test_back_to_back;
    test_wait_ignore;
    test_reset_in_flight;
    test_range;
    test_random;
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/data_mem_responder.md
# data_mem_responder

Memory-side responder for the core's data-memory port. It accepts one request at a time (`request`, `we_re`, `mask`, address, store data), models a fixed number of wait states, and performs a byte-masked write or a full-word read. It completes each access with a single-cycle `valid` pulse and registered load data. It sits between the core's memory-stage outputs and the testbench or top-level memory, replacing the combinational memory stub.

## Interface

**Parameters**
- `DEPTH_WORDS`, default 1024: number of 32-bit words; power of two.
- `LATENCY`, default 2: cycles from request acceptance to `valid`; legal range 1–15.

**Ports** (clock and reset first)
- `clk`  input  1  single clock; all state updates on the rising edge.
- `rst`  input  1  asynchronous, active-high reset.
- `request`  input  1  access request from the core.
- `we_re`  input  1  1 = write, 0 = read.
- `mask`  input  4  byte enables for writes; bit i selects bits [8i+7:8i].
- `address`  input  32  byte address; the word index is `address[log2(DEPTH_WORDS)+1:2]`.
- `store_data`  input  32  write data, already lane-aligned by the core.
- `valid`  output  1  one-cycle completion pulse.
- `load_data`  output  32  read word; meaningful only while `valid`=1.
- `err`  output  1  access fault flag; meaningful only while `valid`=1.
- `busy`  output  1  high while an access is in flight (state WAIT).

## Operation

- FSM states: IDLE, WAIT, RESP.
- **IDLE**: if `request`=1 at the edge, capture `we_re`, `mask`, word index, `store_data`, and the range status.
  - LATENCY=1: go to RESP.
  - Otherwise: go to WAIT with counter = LATENCY−1.
- **WAIT**:
  - Decrement the counter each edge.
  - When the counter is 1 at the edge, go to RESP.
  - `request` is ignored in this state.
- **RESP**: `valid`=1 for exactly this cycle.
  - If `request`=1 at this edge, capture it as in IDLE (back-to-back accept).
  - Otherwise, return to IDLE.
- **Writes**: committed at the edge entering RESP. Only bytes whose `mask` bit is set change. `load_data` = 0 for writes.
- **Reads**:
  - `load_data` is loaded at the edge entering RESP with the full word; `mask` is ignored and the core extracts lanes.
  - A read issued immediately after a write to the same word returns the written data.
- Address bits [1:0] are ignored. No alignment check is made.
- **Reset**:
  - `valid`=0, `err`=0, `busy`=0, `load_data`=0, state IDLE, counter 0.
  - A pending write is discarded.
  - Memory array contents are not reset.

## Timing

- Request accepted at edge k: `valid` is high in the cycle after edge k+LATENCY−1.
- LATENCY=1 gives `valid` in the cycle immediately after the accept edge.
- Throughput: back-to-back accepts in RESP give one access per LATENCY cycles. There are no bubbles.
- `busy` is high exactly during WAIT cycles.
- `valid` is never high on two consecutive cycles when LATENCY>1.
- `valid`, `load_data`, `err`, and `busy` are all registered outputs.
- Reset asserted during WAIT or RESP: outputs drop immediately (asynchronously). The first accept after reset release is at the first edge with `rst`=0.

## Configuration

Macro: `DATA_MEM_RANGE_CHECK_EN`.

- **Defined**:
  - A captured byte address ≥ DEPTH_WORDS×4 completes normally in timing.
  - The response carries `err`=1 and `load_data`=0.
  - No memory write occurs.
- **Undefined**:
  - Upper address bits are discarded, so the address wraps modulo DEPTH_WORDS.
  - `err` is tied to 0.

## Structure

- Package `data_mem_pkg`: FSM state enum (IDLE/WAIT/RESP), `WORD_W`=32, `MASK_W`=4, and the latency-counter width constant (4).
- Sub-module `byte_lane_ram`: a DEPTH_WORDS×32 array with a per-byte write enable and a registered read port.
- The responder top holds the FSM, counter, request capture registers, and range check.

## Test plan

1. LATENCY=2: write 0xDEADBEEF to 0x10 with mask 4'hF, then read 0x10.
   - `valid` appears 2 cycles after each accept; the read returns 0xDEADBEEF.
2. Partial write: mask 4'b0010 with data 0x0000AB00 to 0x10.
   - A subsequent read returns 0xDEADABEF.
3. LATENCY=1: hold `request` high for 4 consecutive reads.
   - `valid` is high on 4 consecutive cycles with the correct data each time; `busy` is never high.
4. LATENCY=3: toggle `request` during WAIT.
   - The extra requests are ignored; exactly one `valid` per accepted request; `busy` is high for 2 cycles.
5. Assert `rst` in WAIT of a write to 0x20, holding 0x12345678.
   - `valid`=0 immediately; a later read of 0x20 returns the old 0x12345678.
6. DEPTH_WORDS=1024 with the macro defined: read address 0x1000.
   - `valid` with `err`=1 and `load_data`=0.
   - With the macro undefined, the same address returns the word at 0x0.
